// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM peripheral and its SPI register map.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pwm_pkg;

    localparam int PWM_CLK_DIV_DEFAULT = 13;
    localparam int PWM_CNT_W           = 8;
    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

    // Register addresses of the five configuration bytes in the SPI register file
    localparam logic [7:0] REG_EN_OUT_7_0   = 8'h00;
    localparam logic [7:0] REG_EN_OUT_15_8  = 8'h01;
    localparam logic [7:0] REG_EN_PWM_7_0   = 8'h02;
    localparam logic [7:0] REG_EN_PWM_15_8  = 8'h03;
    localparam logic [7:0] REG_PWM_DUTY     = 8'h04;

    // Per-pin configuration gathered from the register bytes
    typedef struct packed {
        logic [15:0] en_out;
        logic [15:0] en_pwm;
    } pin_cfg_t;

    // Pin select: disabled pins are low, static pins high, PWM pins follow the shared waveform
    function automatic logic [15:0] pin_drive(input pin_cfg_t cfg, input logic pwm_raw);
        return cfg.en_out & (~cfg.en_pwm | {16{pwm_raw}});
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: free-running 0..CLK_DIV-1 counter, tick_o high while it sits at CLK_DIV-1.
// Latency: tick_o is decoded straight from the counter register, one pulse every CLK_DIV clks.
// Backpressure: none; free-running after reset.
module pwm_tick_gen
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    // Next prescaler value: wrap to zero after the last step
    always_comb begin
        presc_d = presc_q + PW'(1);
        if (presc_q == LAST) begin
            presc_d = '0;
        end
    end

    // Prescaler register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick_o = (presc_q == LAST);

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin output driver: each pin low, static high, or a shared 8-bit PWM with period-shadowed duty.
// Latency: out is registered, 1 clk after the counter compare / enable change; period_start 1 clk after wrap.
// Backpressure: none; free-running, inputs are level configuration bytes.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT,
    parameter int CNT_W   = PWM_CNT_W            // only 8 is supported
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       en_reg_out_7_0,
    input  logic [7:0]       en_reg_out_15_8,
    input  logic [7:0]       en_reg_pwm_7_0,
    input  logic [7:0]       en_reg_pwm_15_8,
    input  logic [CNT_W-1:0] pwm_duty_cycle,
    output logic [15:0]      out,
    output logic             period_start
);

    logic             tick;
    logic             wrap_evt;
    logic             pwm_raw;
    pin_cfg_t         cfg;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] duty_q;
    logic [CNT_W-1:0] duty_d;
    logic [15:0]      out_q;
    logic [15:0]      out_d;
    logic             period_start_q;

    pwm_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    assign cfg.en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign cfg.en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Period boundary: last prescaler step of the last count
    assign wrap_evt = tick && (cnt_q == {CNT_W{1'b1}});

    // Counter advance and duty shadow load; the shadow only moves at the boundary
    // so a mid-period write never shortens or stretches the pulse in flight
    always_comb begin
        cnt_d  = cnt_q;
        duty_d = duty_q;
        if (tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (wrap_evt) begin
            duty_d = pwm_duty_cycle;
        end
    end

    // Raw waveform and pin mux; full-scale duty is forced high so there is no dip at count 255
    always_comb begin
        pwm_raw = (cnt_q < duty_q);
        if (duty_q == {CNT_W{1'b1}}) begin
            pwm_raw = 1'b1;
        end
        out_d = pin_drive(cfg, pwm_raw);
    end

    // State and registered outputs; async reset drops the pins immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            duty_q         <= '0;
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            out_q          <= out_d;
            period_start_q <= wrap_evt;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: static vector table plus multi-period waveform sequences.
// Latency: samples 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_pwm_peripheral;

    localparam int CLK_DIV = 13;
    localparam int PERIOD  = CLK_DIV * 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
    logic [15:0] out;
    logic        period_start;

    always #5 clk = ~clk;

    pwm_peripheral #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (eo_lo),
        .en_reg_out_15_8 (eo_hi),
        .en_reg_pwm_7_0  (ep_lo),
        .en_reg_pwm_15_8 (ep_hi),
        .pwm_duty_cycle  (duty),
        .out             (out),
        .period_start    (period_start)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    typedef struct packed {
        logic [15:0] eo;
        logic [15:0] ep;
        logic [7:0]  d;
        logic [15:0] exp_out;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[7];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   edge_cnt = 0;

    task automatic push_exp(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] act);
        exp_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty actual=%0h", act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s actual=%0h expected=%0h", e.name, act, e.val);
            end
        end
    endtask

    task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep);
        eo_lo = eo[7:0];
        eo_hi = eo[15:8];
        ep_lo = ep[7:0];
        ep_hi = ep[15:8];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    // Advance until period_start is seen, bounded
    task automatic wait_ps(output bit found);
        found = 1'b0;
        for (int i = 0; i < PERIOD + 100; i++) begin
            tick();
            if (period_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Sample one full period of out, starting right after a period_start sample
    task automatic measure(input int b, input logic [15:0] pm, input logic [15:0] hm,
                           input int chg_at, input logic [7:0] chg_duty,
                           output int hi, output int bad, output logic ps_end);
        logic [15:0] lm;
        lm     = ~(pm | hm);
        hi     = 0;
        bad    = 0;
        ps_end = 1'b0;
        for (int j = 0; j < PERIOD; j++) begin
            if (j == chg_at) duty = chg_duty;
            tick();
            if (out[b] === 1'b1) hi++;
            if (((out & pm) != 16'h0) && ((out & pm) != pm)) bad++;
            if ((out & hm) != hm) bad++;
            if ((out & lm) != 16'h0) bad++;
            if (j < PERIOD - 1) begin
                if (period_start !== 1'b0) bad++;
            end else begin
                ps_end = period_start;
            end
        end
    endtask

    task automatic run_windows(input string tag, input int n, input int b,
                               input logic [15:0] pm, input logic [15:0] hm, input int exp_hi);
        int   hi, bad;
        logic ps_end;
        for (int w = 0; w < n; w++) begin
            push_exp({tag, "_high"}, exp_hi);
            push_exp({tag, "_glitch"}, 0);
            push_exp({tag, "_period"}, 1);
            measure(b, pm, hm, -1, 8'h00, hi, bad, ps_end);
            pop_check(hi);
            pop_check(bad);
            pop_check({31'd0, ps_end});
        end
    endtask

    task automatic sync_ps(input string tag);
        bit found;
        push_exp({tag, "_ps_seen"}, 1);
        wait_ps(found);
        pop_check({31'd0, found});
    endtask

    initial begin
        int   hi, bad;
        logic ps_end;
        bit   found;

        vecs[0] = '{eo: 16'h0000, ep: 16'h0000, d: 8'h00, exp_out: 16'h0000};
        vecs[1] = '{eo: 16'h8001, ep: 16'h0000, d: 8'h00, exp_out: 16'h8001};
        vecs[2] = '{eo: 16'h0000, ep: 16'h8001, d: 8'h00, exp_out: 16'h0000};
        vecs[3] = '{eo: 16'hFFFF, ep: 16'h0000, d: 8'h00, exp_out: 16'hFFFF};
        vecs[4] = '{eo: 16'hFFFF, ep: 16'hFF00, d: 8'h80, exp_out: 16'h00FF};
        vecs[5] = '{eo: 16'h1234, ep: 16'h0000, d: 8'h80, exp_out: 16'h1234};
        vecs[6] = '{eo: 16'hA5A5, ep: 16'h0F0F, d: 8'h80, exp_out: 16'hA0A0};

        rst_n = 1'b0;
        set_cfg(16'h0000, 16'h0000);
        duty = 8'h00;
        #12;
        push_exp("reset_out", 0);
        pop_check({16'd0, out});
        push_exp("reset_period_start", 0);
        pop_check({31'd0, period_start});

        @(negedge clk);
        rst_n    = 1'b1;
        edge_cnt = 0;

        // Static selects; during the first period the shadow duty is 0 so PWM pins read low
        for (int i = 0; i < 7; i++) begin
            set_cfg(vecs[i].eo, vecs[i].ep);
            duty = vecs[i].d;
            push_exp($sformatf("vec%0d_out", i), {16'd0, vecs[i].exp_out});
            tick();
            pop_check({16'd0, out});
        end

        // First period boundary lands exactly one full period after reset release
        set_cfg(16'h00FF, 16'h00FF);
        duty = 8'h80;
        sync_ps("first");
        push_exp("first_ps_edge", PERIOD);
        pop_check(edge_cnt);

        run_windows("duty80", 1, 0, 16'h00FF, 16'h0000, 1664);

        set_cfg(16'hFFFF, 16'hFFFF);
        duty = 8'h00;
        sync_ps("duty00");
        run_windows("duty00", 3, 5, 16'hFFFF, 16'h0000, 0);

        duty = 8'hFF;
        sync_ps("dutyFF");
        run_windows("dutyFF", 3, 9, 16'hFFFF, 16'h0000, PERIOD);

        duty = 8'h01;
        sync_ps("duty01");
        run_windows("duty01", 1, 15, 16'hFFFF, 16'h0000, 13);

        // Mid-period duty write only takes effect at the next boundary
        duty = 8'h40;
        sync_ps("midupd");
        push_exp("midupd_cur_high", 832);
        push_exp("midupd_cur_glitch", 0);
        push_exp("midupd_cur_period", 1);
        measure(0, 16'hFFFF, 16'h0000, 32 * CLK_DIV, 8'hC0, hi, bad, ps_end);
        pop_check(hi);
        pop_check(bad);
        pop_check({31'd0, ps_end});
        run_windows("midupd_next", 1, 0, 16'hFFFF, 16'h0000, 2496);

        // Mixed: even pins static high, odd pins PWM phase-aligned
        set_cfg(16'hFFFF, 16'hAAAA);
        duty = 8'h40;
        sync_ps("mixed");
        run_windows("mixed", 1, 1, 16'hAAAA, 16'h5555, 832);

        for (int i = 0; i < 1664; i++) tick();
        push_exp("toggle_pre_out1", 0);
        pop_check({31'd0, out[1]});
        set_cfg(16'hFFFF, 16'hAAA8);
        tick();
        push_exp("toggle_post_out1", 1);
        pop_check({31'd0, out[1]});
        push_exp("toggle_post_out3", 0);
        pop_check({31'd0, out[3]});
        set_cfg(16'hFFFF, 16'hAAAA);
        tick();
        push_exp("toggle_back_out1", 0);
        pop_check({31'd0, out[1]});

        // Asynchronous reset mid-period with all pins high
        set_cfg(16'hFFFF, 16'h0000);
        tick();
        push_exp("async_pre_out", 16'hFFFF);
        pop_check({16'd0, out});
        #2;
        rst_n = 1'b0;
        #1;
        push_exp("async_out", 0);
        pop_check({16'd0, out});
        push_exp("async_period_start", 0);
        pop_check({31'd0, period_start});
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        push_exp("async_release_out", 16'hFFFF);
        pop_check({16'd0, out});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
